// File: rtl/fnd_display_ctrl_pkg.sv
// rtl/fnd_display_ctrl_pkg.sv - shared types and segment constants for the FND display
package fnd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } conv_state_e;

    localparam int DEFAULT_REFRESH_DIV = 100_000;

    // Common-anode patterns, {dp,g,f,e,d,c,b,a}, active-low.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/fnd_display_ctrl_if.sv
// rtl/fnd_display_ctrl_if.sv - balance/enable inputs and FND outputs of the display stage
interface fnd_display_ctrl_if;
    logic [15:0] coin_val;
    logic        seg_en;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        busy;

    modport master (output coin_val, output seg_en, input an, input seg, input busy);
    modport slave  (input coin_val, input seg_en, output an, output seg, output busy);
endinterface

// File: rtl/fnd_display_ctrl_bin2bcd_seq.sv
// rtl/fnd_display_ctrl_bin2bcd_seq.sv - sequential 16-iteration double-dabble converter
import fnd_pkg::*;

module bin2bcd_seq #(
    parameter int MAX_DISP = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd,
    output logic        ovf
);

    localparam logic [16:0] MAX_LIM = 17'(MAX_DISP);

    conv_state_e state_q, state_d;
    logic [31:0] shift_q, shift_d;   // {bcd accumulator, binary remainder}
    logic [3:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic [31:0] adj;

    // State, shift register, iteration count and overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next state: capture on start, add-3/shift for 16 cycles, one DONE cycle.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        adj     = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d = {16'h0000, bin};
                    cnt_d   = '0;
                    ovf_d   = {1'b0, bin} > MAX_LIM;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                for (int i = 0; i < 4; i++) begin
                    if (adj[16 + 4*i +: 4] >= 4'd5) begin
                        adj[16 + 4*i +: 4] = adj[16 + 4*i +: 4] + 4'd3;
                    end
                end
                shift_d = {adj[30:0], 1'b0};
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign bcd  = shift_q[31:16];
    assign ovf  = ovf_q;

endmodule

// File: rtl/fnd_display_ctrl.sv
// rtl/fnd_display_ctrl.sv - 4-digit multiplexed FND driver with change-triggered BCD conversion
import fnd_pkg::*;

module fnd_display_ctrl #(
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
    parameter int MAX_DISP    = 9999
) (
    input  logic          clk,
    input  logic          reset,
    fnd_display_ctrl_if.slave disp
);

    localparam int             CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]  SCAN_TC = CW'(REFRESH_DIV - 1);

    logic [15:0]   last_val_q;
    logic          start_q;
    logic [15:0]   disp_q;
    logic          ovf_q;
    logic [CW-1:0] scan_q;
    logic [1:0]    digit_q;
    logic [3:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;

    logic          conv_busy;
    logic          conv_done;
    logic [15:0]   conv_bcd;
    logic          conv_ovf;
    logic [3:0]    lead_zero;
    logic [3:0]    nib;

    bin2bcd_seq #(.MAX_DISP(MAX_DISP)) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (start_q),
        .bin   (last_val_q),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    // Change detection: only sampled while the converter is idle, so mid-conversion edits are picked up afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_val_q <= '0;
            start_q    <= 1'b0;
        end else if (start_q) begin
            start_q <= 1'b0;
        end else if (!conv_busy && (disp.coin_val != last_val_q)) begin
            last_val_q <= disp.coin_val;
            start_q    <= 1'b1;
        end
    end

    // Display latch: all four nibbles and the overflow flag move together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else if (conv_done) begin
            disp_q <= conv_bcd;
            ovf_q  <= conv_ovf;
        end
    end

    // Scan timer: advance the digit index once per REFRESH_DIV cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_q  <= '0;
            digit_q <= '0;
        end else if (scan_q == SCAN_TC) begin
            scan_q  <= '0;
            digit_q <= digit_q + 2'd1;
        end else begin
            scan_q <= scan_q + 1'b1;
        end
    end

    // Segment/anode decode with leading-zero blanking and overflow dashes.
    always_comb begin
        lead_zero    = 4'b0000;
        lead_zero[3] = (disp_q[15:12] == 4'd0);
        lead_zero[2] = lead_zero[3] && (disp_q[11:8] == 4'd0);
        lead_zero[1] = lead_zero[2] && (disp_q[7:4] == 4'd0);
        nib          = disp_q[{digit_q, 2'b00} +: 4];
        an_d         = 4'hF;
        seg_d        = SEG_BLANK;
        if (disp.seg_en) begin
            an_d = ~(4'b0001 << digit_q);
            if (ovf_q) begin
                seg_d = SEG_DASH;
            end else if (lead_zero[digit_q]) begin
                seg_d = SEG_BLANK;
            end else begin
                seg_d = seg_digit(nib);
            end
        end
    end

    // Registered FND outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q  <= 4'hF;
            seg_q <= SEG_BLANK;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign disp.an   = an_q;
    assign disp.seg  = seg_q;
    assign disp.busy = conv_busy;

endmodule

// File: tb/tb_fnd_display_ctrl.sv
// tb/tb_fnd_display_ctrl.sv - self-checking bench for fnd_display_ctrl
module tb_fnd_display_ctrl;

    localparam int RD = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    fnd_display_ctrl_if disp_if ();

    fnd_display_ctrl #(.REFRESH_DIV(RD), .MAX_DISP(9999)) dut (
        .clk   (clk),
        .reset (reset),
        .disp  (disp_if)
    );

    always #5 clk = ~clk;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic logic [7:0] model_seg(input int v, input int p);
        int pw;
        pw = 10 ** p;
        if (v > 9999) return 8'hBF;
        if (p > 0 && v < pw) return 8'hFF;
        return seg_tab[(v / pw) % 10];
    endfunction

    function automatic logic [15:0] model_latch(input int v);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r = r | 16'(((v / (10 ** k)) % 10) << (4 * k));
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic conv_len(output int n);
        int w;
        w = 0;
        n = 0;
        while (disp_if.busy !== 1'b1 && w < 6) begin @(negedge clk); w++; end
        while (disp_if.busy === 1'b1 && n < 40) begin @(negedge clk); n++; end
    endtask

    task automatic check_display(input int v, input bit en, input string tag);
        logic [3:0] seen;
        int p;
        seen = '0;
        repeat (4 * RD + 4) begin
            @(negedge clk);
            if (!en) begin
                chk({tag, "_an_off"}, disp_if.an, 4'hF);
                chk({tag, "_seg_off"}, disp_if.seg, 8'hFF);
            end else begin
                case (disp_if.an)
                    4'hE:    p = 0;
                    4'hD:    p = 1;
                    4'hB:    p = 2;
                    4'h7:    p = 3;
                    default: p = -1;
                endcase
                chk({tag, "_an_onehot"}, (p >= 0), 1);
                if (p >= 0) begin
                    seen[p] = 1'b1;
                    chk($sformatf("%s_seg%0d", tag, p), disp_if.seg, model_seg(v, p));
                end
            end
        end
        if (en) chk({tag, "_scan_cover"}, seen, 4'hF);
    endtask

    initial begin
        int n;
        int v, prev;
        bit en;

        disp_if.coin_val = 16'd0;
        disp_if.seg_en   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_an", disp_if.an, 4'hF);
        chk("rst_seg", disp_if.seg, 8'hFF);
        chk("rst_busy", disp_if.busy, 1'b0);
        chk("rst_latch", dut.disp_q, 16'h0000);

        reset = 1'b0;
        disp_if.seg_en = 1'b1;
        check_display(0, 1'b1, "zero");

        disp_if.coin_val = 16'd300;
        conv_len(n);
        chk("busy_len_300", n, 17);
        chk("latch_300", dut.disp_q, model_latch(300));
        check_display(300, 1'b1, "v300");

        disp_if.coin_val = 16'd1234;
        n = 0;
        while (disp_if.busy !== 1'b1 && n < 6) begin @(negedge clk); n++; end
        chk("busy_rise_1234", disp_if.busy, 1'b1);
        repeat (4) @(negedge clk);
        disp_if.coin_val = 16'd500;
        n = 0;
        while (disp_if.busy === 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk("latch_first_1234", dut.disp_q, model_latch(1234));
        conv_len(n);
        chk("busy_len_500", n, 17);
        chk("latch_500", dut.disp_q, model_latch(500));
        check_display(500, 1'b1, "v500");

        disp_if.coin_val = 16'd10000;
        conv_len(n);
        chk("busy_len_10000", n, 17);
        check_display(10000, 1'b1, "ovf");
        disp_if.coin_val = 16'd9999;
        conv_len(n);
        chk("busy_len_9999", n, 17);
        check_display(9999, 1'b1, "v9999");

        disp_if.seg_en   = 1'b0;
        disp_if.coin_val = 16'd700;
        conv_len(n);
        chk("latch_700_off", dut.disp_q, model_latch(700));
        check_display(700, 1'b0, "off700");
        disp_if.seg_en = 1'b1;
        check_display(700, 1'b1, "on700");

        disp_if.coin_val = 16'd300;
        n = 0;
        while (disp_if.busy !== 1'b1 && n < 6) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        chk("busy_before_rst", disp_if.busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("midrst_an", disp_if.an, 4'hF);
        chk("midrst_seg", disp_if.seg, 8'hFF);
        chk("midrst_busy", disp_if.busy, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        conv_len(n);
        chk("busy_len_restart", n, 17);
        chk("latch_restart", dut.disp_q, model_latch(300));
        check_display(300, 1'b1, "restart");

        prev = 300;
        for (int i = 0; i < 10; i++) begin
            v  = int'($urandom_range(0, 12000));
            if (v == prev) v = v + 1;
            en = 1'($urandom_range(0, 1));
            disp_if.seg_en   = en;
            disp_if.coin_val = 16'(v);
            conv_len(n);
            chk($sformatf("rnd%0d_busy_len", i), n, 17);
            if (v <= 9999) chk($sformatf("rnd%0d_latch", i), dut.disp_q, model_latch(v));
            check_display(v, en, $sformatf("rnd%0d", i));
            prev = v;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fnd_display_ctrl.md
# fnd_display_ctrl

Downstream display stage for the coffee machine. It takes the live balance (`coin_val`) and the display enable (`seg_en`) and drives a 4-digit common-anode 7-segment FND. Conversion from binary to BCD is sequential and runs whenever the value changes. Digits are time-multiplexed at a fixed scan rate.

## Interface
Parameters:
- `REFRESH_DIV`, default 100_000: clk cycles per digit slot (1 ms at 100 MHz).
- `MAX_DISP`, default 9999: largest displayable value; anything above shows dashes.

Ports (reset is asynchronous, active-high; clock is `clk`):
- `clk`  in  1  100 MHz system clock
- `reset`  in  1  asynchronous, active-high reset
- `coin_val`  in  16  balance in won, unsigned
- `seg_en`  in  1  display enable; 0 blanks the whole display
- `an`  out  4  digit anodes, active-low; `an[0]` is the units digit
- `seg`  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
- `busy`  out  1  high while a BCD conversion is in progress

## Operation
- Conversion FSM has three states:
  - **IDLE**: if `coin_val != last_val`, capture `coin_val` into `last_val` and the shift register, clear the BCD accumulator, set iteration count = 0, go to CONV.
  - **CONV**: one double-dabble iteration per cycle. First add 3 to each BCD nibble ≥ 5, then shift {bcd, bin} left by 1. After 16 iterations go to DONE.
  - **DONE**: write the 4 BCD nibbles and the overflow flag into the display latch in a single update, then return to IDLE.
- Overflow flag = captured value > `MAX_DISP`. When set, all four digits show "-" (segment g only).
- Changes to `coin_val` during CONV/DONE are ignored. The comparison in IDLE picks them up afterwards, so the final displayed value always equals the last stable input.
- Leading-zero blanking: a digit is blank if it and every digit above it is zero. The units digit is never blanked, so value 0 shows "   0".
- Scan: a counter runs 0..`REFRESH_DIV`-1. On terminal count, the digit index advances 0→1→2→3→0.
- `seg_en` = 0: `an` = 4'hF and `seg` = 8'hFF. The scan counter and conversion keep running.
- `dp` is always off (bit 7 = 1).
- Reset mid-conversion aborts immediately and returns to the reset state.

## Timing
- Reset values:
  - `an` = 4'hF, `seg` = 8'hFF, `busy` = 0.
  - FSM in IDLE; `last_val` = 0; display latch = 0, overflow = 0.
  - Scan counter = 0, digit index = 0.
- Latency from a `coin_val` change (seen at clk edge N):
  - `busy` rises at N+1.
  - Latch updated at N+18.
  - `busy` falls at N+18.
  - Visible on the next scan of each digit.
- `an`/`seg` are registered and change one cycle after the digit index changes. Only one `an` bit is low at a time.
- Digit period is 4×`REFRESH_DIV` cycles (4 ms by default).
- `seg_en` takes effect on outputs one cycle after it changes.

## Structure
- Package `fnd_pkg`:
  - FSM state enum (IDLE, CONV, DONE).
  - Segment constants for 0–9, BLANK (8'hFF), DASH (8'hBF).
  - Default `REFRESH_DIV`.
- Sub-module `bin2bcd_seq`: holds the IDLE/CONV/DONE FSM and the 16-iteration double-dabble.
  - Ports: `clk`, `reset`, `start`, `bin[15:0]`, `busy`, `done`, `bcd[15:0]`, `ovf`.
- The top level holds change detection, the display latch, blanking, the scan counter and segment decode.

## Test plan
Run with `REFRESH_DIV` = 4 for speed.
- Reset, then `seg_en` = 1, `coin_val` = 0 → after the first scan, digits read "   0": only `an[0]` shows 8'hC0; `an[1..3]` show 8'hFF.
- `coin_val` 0→300 → `busy` high for exactly 17 cycles. Latch = 0x0300. Scan shows an[0]=0, an[1]=0, an[2]=3 (8'hB0), an[3] blank.
- `coin_val` = 1234, then changed to 500 on the 5th cycle of CONV → first latch = 1234. A second conversion follows immediately, and the final latch is 0500, shown as " 500".
- `coin_val` = 10000 → all four digits show 8'hBF. Then `coin_val` = 9999 → "9999" (8'h90 on each digit).
- `seg_en` = 0 with `coin_val` = 700 → `an` stays 4'hF, `seg` = 8'hFF. The latch still updates to 0x0700. `seg_en` → 1 shows " 700".
- Assert `reset` during CONV → outputs go to reset values on the same cycle, `busy` = 0. After release with `coin_val` held at 300, the conversion restarts and completes.
